dvi_timing_gen: RTL and testbench

DVI_TIMING_GEN -- requirements
Module: dvi_timing_gen

---
 rtl/dvi_timing_pkg.sv | 39 +++
 rtl/ready_sync.sv | 24 ++
 rtl/dvi_timing_gen.sv | 127 ++++++++++++
 tb/tb_dvi_timing_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dvi_timing_pkg.sv
// Shared 640x480@60 timing constants, FSM state encoding and output payload
// for the DVI timing generator.
package dvi_timing_pkg;

   localparam int unsigned CNT_W = 10;

   localparam int unsigned H_ACTIVE     = 640;
   localparam int unsigned H_FP         = 16;
   localparam int unsigned H_SYNC       = 96;
   localparam int unsigned H_BP         = 48;
   localparam int unsigned H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned H_SYNC_START = H_ACTIVE + H_FP;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;

   localparam int unsigned V_ACTIVE     = 480;
   localparam int unsigned V_FP         = 10;
   localparam int unsigned V_SYNC       = 2;
   localparam int unsigned V_BP         = 33;
   localparam int unsigned V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned V_SYNC_START = V_ACTIVE + V_FP;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   typedef struct packed {
      logic             hsync;
      logic             vsync;
      logic             de;
      logic [CNT_W-1:0] px_x;
      logic [CNT_W-1:0] px_y;
      logic             frame_start;
      logic             running;
   } vid_out_t;

endpackage

// File: rtl/ready_sync.sv
// Two-flop synchronizer bringing the asynchronous DCM lock into the pixel domain.
module ready_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/dvi_timing_gen.sv
// 640x480 DVI raster timing generator: waits for a stable DCM lock, then scans
// out h/v counters and decodes them into registered sync/de/pixel outputs.
module dvi_timing_gen
   import dvi_timing_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter logic        SYNC_POL      = 1'b0
) (
   input  logic             fbclk,
   input  logic             rst_b,
   input  logic             ready,
   output logic             hsync,
   output logic             vsync,
   output logic             de,
   output logic [CNT_W-1:0] px_x,
   output logic [CNT_W-1:0] px_y,
   output logic             frame_start,
   output logic             running
);

   localparam int unsigned SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

   localparam vid_out_t OUT_IDLE = '{
      hsync:       ~SYNC_POL,
      vsync:       ~SYNC_POL,
      de:          1'b0,
      px_x:        '0,
      px_y:        '0,
      frame_start: 1'b0,
      running:     1'b0
   };

   logic             rdy_s;
   state_t           state_q,  state_d;
   logic [SET_W-1:0] settle_q, settle_d;
   logic [CNT_W-1:0] h_cnt_q,  h_cnt_d;
   logic [CNT_W-1:0] v_cnt_q,  v_cnt_d;
   vid_out_t         out_q,    out_d;
   logic             h_act,    v_act;

   ready_sync u_ready_sync (
      .clk   (fbclk),
      .rst_n (rst_b),
      .d     (ready),
      .q     (rdy_s)
   );

   always_ff @(posedge fbclk or negedge rst_b) begin
      if (!rst_b) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         h_cnt_q  <= '0;
         v_cnt_q  <= '0;
         out_q    <= OUT_IDLE;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         h_cnt_q  <= h_cnt_d;
         v_cnt_q  <= v_cnt_d;
         out_q    <= out_d;
      end
   end

   // Next state and raster counters; counters sit at 0 unless scanning.
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      h_cnt_d  = '0;
      v_cnt_d  = '0;
      case (state_q)
         ST_IDLE: begin
            settle_d = '0;
            if (rdy_s) state_d = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!rdy_s) begin
               state_d  = ST_IDLE;
               settle_d = '0;
            end else if (settle_q == SET_LAST) begin
               state_d = ST_RUN;
            end else begin
               settle_d = settle_q + SET_W'(1);
            end
         end
         ST_RUN: begin
            if (!rdy_s) begin
               state_d = ST_IDLE;
            end else if (h_cnt_q == CNT_W'(H_TOTAL - 1)) begin
               h_cnt_d = '0;
               v_cnt_d = (v_cnt_q == CNT_W'(V_TOTAL - 1)) ? '0 : v_cnt_q + CNT_W'(1);
            end else begin
               h_cnt_d = h_cnt_q + CNT_W'(1);
               v_cnt_d = v_cnt_q;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode of the current counters, presented one cycle later.
   always_comb begin
      out_d = OUT_IDLE;
      h_act = (h_cnt_q < CNT_W'(H_ACTIVE));
      v_act = (v_cnt_q < CNT_W'(V_ACTIVE));
      if (state_q == ST_RUN) begin
         out_d.running     = 1'b1;
         out_d.de          = h_act && v_act;
         out_d.px_x        = (h_act && v_act) ? h_cnt_q : '0;
         out_d.px_y        = (h_act && v_act) ? v_cnt_q : '0;
         out_d.frame_start = (h_cnt_q == '0) && (v_cnt_q == '0);
         if (h_cnt_q >= CNT_W'(H_SYNC_START) && h_cnt_q < CNT_W'(H_SYNC_END))
            out_d.hsync = SYNC_POL;
         if (v_cnt_q >= CNT_W'(V_SYNC_START) && v_cnt_q < CNT_W'(V_SYNC_END))
            out_d.vsync = SYNC_POL;
      end
   end

   assign hsync       = out_q.hsync;
   assign vsync       = out_q.vsync;
   assign de          = out_q.de;
   assign px_x        = out_q.px_x;
   assign px_y        = out_q.px_y;
   assign frame_start = out_q.frame_start;
   assign running     = out_q.running;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Scoreboard bench for dvi_timing_gen: a lock-length/pixel-index reference model
// predicts every output cycle, a negedge monitor compares against the DUT.
module tb_dvi_timing_gen;

   localparam logic POL    = 1'b0;
   localparam int   SETTLE = 16;

   typedef struct packed {
      logic       hs;
      logic       vs;
      logic       de;
      logic [9:0] x;
      logic [9:0] y;
      logic       fs;
      logic       run;
   } obs_t;

   logic       fbclk = 1'b0;
   logic       rst_b;
   logic       ready;
   logic       hsync, vsync, de, frame_start, running;
   logic [9:0] px_x, px_y;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   bit   mon_en   = 1'b0;
   int   cyc      = 0;

   // Reference model: two-stage delay of ready, then run length of stable lock.
   bit   m_d1, m_d2;
   int   lock_len;

   dvi_timing_gen #(.SETTLE_CYCLES(SETTLE), .SYNC_POL(POL)) dut (
      .fbclk       (fbclk),
      .rst_b       (rst_b),
      .ready       (ready),
      .hsync       (hsync),
      .vsync       (vsync),
      .de          (de),
      .px_x        (px_x),
      .px_y        (px_y),
      .frame_start (frame_start),
      .running     (running)
   );

   always #20 fbclk = ~fbclk;

   function automatic obs_t idle_obs();
      obs_t o;
      o = '{hs: ~POL, vs: ~POL, de: 1'b0, x: 10'd0, y: 10'd0, fs: 1'b0, run: 1'b0};
      return o;
   endfunction

   // Outputs follow from how long the synchronized lock has been stable:
   // SETTLE+1 stable samples reach scan-out, each further one is one pixel clock.
   function automatic obs_t expect_at(int len);
      obs_t o;
      int   n, h, v;
      o = idle_obs();
      if (len >= SETTLE + 1) begin
         n = len - (SETTLE + 1);
         h = n % 800;
         v = (n / 800) % 525;
         o.run = 1'b1;
         o.de  = (h < 640) && (v < 480);
         o.x   = o.de ? 10'(h) : 10'd0;
         o.y   = o.de ? 10'(v) : 10'd0;
         o.fs  = (h == 0) && (v == 0);
         o.hs  = (h >= 656 && h <= 751) ? POL : ~POL;
         o.vs  = (v >= 490 && v <= 491) ? POL : ~POL;
      end
      return o;
   endfunction

   function automatic obs_t dut_obs();
      obs_t o;
      o = '{hs: hsync, vs: vsync, de: de, x: px_x, y: px_y, fs: frame_start, run: running};
      return o;
   endfunction

   function automatic void check(string name, obs_t got, obs_t want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s @cycle %0d: got hs=%0b vs=%0b de=%0b x=%0d y=%0d fs=%0b run=%0b, want hs=%0b vs=%0b de=%0b x=%0d y=%0d fs=%0b run=%0b",
                  name, cyc, got.hs, got.vs, got.de, got.x, got.y, got.fs, got.run,
                  want.hs, want.vs, want.de, want.x, want.y, want.fs, want.run);
      end
   endfunction

   // One clock: sample inputs seen by the edge, drive next inputs, push prediction.
   task automatic clk_cycle(input logic nr, input logic nrst, output obs_t pushed);
      logic rin, rst_at, y;
      @(posedge fbclk);
      rin    = ready;
      rst_at = rst_b;
      cyc++;
      #1;
      ready = nr;
      rst_b = nrst;
      if (!rst_b || !rst_at) begin
         m_d1     = 1'b0;
         m_d2     = 1'b0;
         lock_len = 0;
         pushed   = idle_obs();
      end else begin
         pushed   = expect_at(lock_len);
         y        = m_d2;
         m_d2     = m_d1;
         m_d1     = rin;
         lock_len = y ? lock_len + 1 : 0;
      end
      exp_q.push_back(pushed);
   endtask

   task automatic run(input logic nr, input logic nrst, input int n);
      obs_t o;
      for (int i = 0; i < n; i++) clk_cycle(nr, nrst, o);
   endtask

   task automatic run_until(input int x, input int y, input int budget);
      obs_t o;
      bit   hit;
      hit = 1'b0;
      for (int i = 0; i < budget && !hit; i++) begin
         clk_cycle(1'b1, 1'b1, o);
         hit = o.de && (o.x == 10'(x)) && (o.y == 10'(y));
      end
      n_checks++;
      if (!hit) begin
         n_fail++;
         $display("FAIL run_until: pixel (%0d,%0d) not predicted within %0d cycles", x, y, budget);
      end
   endtask

   always @(negedge fbclk) begin
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_underflow @cycle %0d: got empty queue, want one entry", cyc);
         end else begin
            check("scoreboard", dut_obs(), exp_q.pop_front());
         end
      end
   end

   initial begin
      int hi, lo;
      m_d1     = 1'b0;
      m_d2     = 1'b0;
      lock_len = 0;
      ready    = 1'b1;
      rst_b    = 1'b1;
      #2 rst_b = 1'b0;
      #3 check("async_reset_idle", dut_obs(), idle_obs());
      mon_en = 1'b1;

      // Reset held with ready high, then release and lock.
      run(1'b1, 1'b0, 10);
      run(1'b1, 1'b1, 60 + 3 * 800);

      // Ready loss, re-lock interrupted by a one-cycle glitch in settle.
      run(1'b0, 1'b1, 3);
      run(1'b1, 1'b1, 10);
      run(1'b0, 1'b1, 1);
      run(1'b1, 1'b1, 40 + 2 * 800);

      // Ready lost mid-line, then re-acquired.
      run_until(100, 4, 5000);
      run(1'b0, 1'b1, 2);
      run(1'b1, 1'b1, 1200);

      // Reset pulse mid-frame, then restart after settle.
      run_until(320, 3, 5000);
      run(1'b1, 1'b0, 3);
      run(1'b1, 1'b1, 40 + 900);

      // Randomized lock/loss/reset sequences.
      for (int it = 0; it < 14; it++) begin
         hi = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 22) : $urandom_range(30, 2400);
         lo = $urandom_range(1, 6);
         run(1'b1, 1'b1, hi);
         if ($urandom_range(0, 4) == 0) run(1'b1, 1'b0, lo);
         else                           run(1'b0, 1'b1, lo);
      end
      run(1'b1, 1'b1, 900);

      @(negedge fbclk);
      #1;
      mon_en = 1'b0;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
